sync_timing_gen: RTL
====================

SYNC_TIMING_GEN -- requirements
Module: sync_timing_gen

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 2, meaning sync pulse length in enabled ticks.
REQ-002 SHALL have parameter BP_LEN, default 33, meaning back-porch length in ticks.
REQ-003 SHALL have parameter ACT_LEN, default 480, meaning visible-area length in ticks.
REQ-004 SHALL have parameter FP_LEN, default 10, meaning front-porch length in ticks.
REQ-005 SHALL have parameter CNT_W, default 10, meaning the phase-counter width; it SHALL hold max(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN)-1.
REQ-006 SHALL have parameter IDX_W, default 9, meaning the o_idx width; 2^IDX_W >= ACT_LEN.
REQ-007 SHALL have parameter SYNC_POL, default 1, meaning the o_sync level during the sync phase (1 = active-high, 0 = active-low).
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port i_sclr, input, 1 bit, the synchronous active-high reset/clear.
REQ-010 SHALL have port i_en, input, 1 bit, the tick enable (pixel tick for horizontal, line-end for vertical).
REQ-011 SHALL have port o_sync, output, 1 bit, the sync pulse at SYNC_POL polarity.
REQ-012 SHALL have port o_act, output, 1 bit, high during the visible area.
REQ-013 SHALL have port o_idx, output, IDX_W bits, the position within the visible area.
REQ-014 SHALL have port o_last, output, 1 bit, high during the final tick of the period.
REQ-015 SHALL have port o_phase, output, 2 bits, the current phase (0 SYNC, 1 BP, 2 ACT, 3 FP).

Function
REQ-016 SHALL implement a Moore FSM with states SYNC -> BP -> ACT -> FP -> SYNC, plus a CNT_W-bit up-counter for the tick position within the current phase.
REQ-017 SHALL advance state and counter only on clk edges where i_en=1; with i_en=0 all state and outputs SHALL hold.
REQ-018 SHALL, with i_en=1, increment the counter; when counter = phase length-1 it SHALL instead clear the counter to 0 and move to the next state.
REQ-019 SHALL decode every output from registered state only, with no combinational path from i_en to any output.
REQ-020 SHALL drive o_sync = SYNC_POL in SYNC and ~SYNC_POL otherwise.
REQ-021 SHALL drive o_act = 1 only in ACT.
REQ-022 SHALL drive o_idx = the counter value truncated to IDX_W bits in ACT, and 0 otherwise.
REQ-023 SHALL drive o_last = 1 only in FP with counter = FP_LEN-1, i.e. exactly one tick per period of SYNC_LEN+BP_LEN+ACT_LEN+FP_LEN ticks.
REQ-024 SHALL support cascading: a vertical instance driven by i_en = h.o_last & h_tick SHALL advance exactly once per line.
REQ-025 SHALL make any phase length of 1 legal; that phase lasts exactly one enabled tick.
REQ-026 SHALL treat a zero phase length as illegal, flagged by a simulation-only check at elaboration.
REQ-027 SHALL let i_sclr take priority over i_en when both are asserted in the same cycle.

Reset
REQ-028 SHALL, on a clk edge with i_sclr=1, go to state SYNC with counter 0 regardless of i_en or current state, including mid-period.
REQ-029 SHALL hold these output values after reset: o_sync=SYNC_POL, o_act=0, o_idx=0, o_last=0, o_phase=0.
REQ-030 SHALL make the first enabled tick after reset release count as SYNC tick 1 (the counter goes 0 -> 1).

Structure
REQ-031 SHALL keep phase encodings and the standard 640x480@60 horizontal/vertical timing constants in the shared header vga_timing.vh.
REQ-032 SHALL reuse counterN_en as the phase-position counter, with its clear driven by i_sclr or phase wrap.
REQ-033 SHALL be usable so that existing hsync/vsync wrappers become two parameterised instances of this block.

Verification
REQ-034 SHALL test defaults with i_en=1 continuously: o_sync high for 2 cycles, o_act rises at tick 35 and falls at tick 515, o_last pulses once at tick 524, and the period is 525.
REQ-035 SHALL test o_idx in ACT: it reads 0,1,...,479 with 0 outside ACT; with IDX_W=9 there is no wrap.
REQ-036 SHALL test i_en toggled 1/0 alternately: all outputs hold on i_en=0 cycles and the period equals 1050 clk cycles.
REQ-037 SHALL test i_sclr asserted in ACT at idx 200 together with i_en=1: the next cycle shows o_phase=0, o_idx=0, o_act=0, and the count restarts.
REQ-038 SHALL test SYNC_POL=0 with SYNC_LEN=96, BP_LEN=48, ACT_LEN=640, FP_LEN=16: o_sync is low for 96 ticks and the period is 800.
REQ-039 SHALL test a cascade of H (800) and V (525) instances: V o_last pulses once every 420000 ticks, and V o_idx increments only on H o_last ticks.

Source files
------------

// File: rtl/sync_timing_gen_pkg.sv
// Shared phase encoding and standard 640x480@60 timing constants
// for the sync timing generator and its wrappers.
package sync_timing_gen_pkg;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;

  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_SYNC;
    unique case (p)
      PH_SYNC: n = PH_BP;
      PH_BP:   n = PH_ACT;
      PH_ACT:  n = PH_FP;
      PH_FP:   n = PH_SYNC;
      default: n = PH_SYNC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_timing_gen_counterN_en.sv
// Enabled up-counter with synchronous clear; clear wins over enable.
// Used as the position-within-phase counter.
module counterN_en #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, increment on enable, else hold
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/sync_timing_gen.sv
// Generic sync/porch/active timing generator: one instance per axis,
// vertical cascades off the horizontal o_last.
module sync_timing_gen
  import sync_timing_gen_pkg::*;
#(
  parameter int   SYNC_LEN = 2,
  parameter int   BP_LEN   = 33,
  parameter int   ACT_LEN  = 480,
  parameter int   FP_LEN   = 10,
  parameter int   CNT_W    = 10,
  parameter int   IDX_W    = 9,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  output logic             o_sync,
  output logic             o_act,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic [1:0]       o_phase
);

  localparam logic [CNT_W-1:0] SYNC_M1 = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] BP_M1   = CNT_W'(BP_LEN - 1);
  localparam logic [CNT_W-1:0] ACT_M1  = CNT_W'(ACT_LEN - 1);
  localparam logic [CNT_W-1:0] FP_M1   = CNT_W'(FP_LEN - 1);

  localparam int MAX_LEN =
    (SYNC_LEN > BP_LEN ? SYNC_LEN : BP_LEN) >
    (ACT_LEN > FP_LEN ? ACT_LEN : FP_LEN) ?
    (SYNC_LEN > BP_LEN ? SYNC_LEN : BP_LEN) :
    (ACT_LEN > FP_LEN ? ACT_LEN : FP_LEN);

  if (SYNC_LEN < 1 || BP_LEN < 1 || ACT_LEN < 1 || FP_LEN < 1) begin : g_len_chk
    $error("sync_timing_gen: zero phase length is illegal");
  end

  if ((64'd1 << CNT_W) < 64'(MAX_LEN)) begin : g_cnt_chk
    $error("sync_timing_gen: CNT_W too small for longest phase");
  end

  phase_e           state_q;
  phase_e           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_m1;
  logic             wrap;
  logic             clr;

  // last count value of the current phase
  always_comb begin
    len_m1 = SYNC_M1;
    unique case (state_q)
      PH_SYNC: len_m1 = SYNC_M1;
      PH_BP:   len_m1 = BP_M1;
      PH_ACT:  len_m1 = ACT_M1;
      PH_FP:   len_m1 = FP_M1;
      default: len_m1 = SYNC_M1;
    endcase
  end

  assign wrap = (cnt == len_m1);
  assign clr  = i_sclr | (i_en & wrap);

  counterN_en #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .i_clr (clr),
    .i_en  (i_en),
    .o_cnt (cnt)
  );

  // next phase: advance only on an enabled tick at phase end
  always_comb begin
    state_d = state_q;
    if (i_en && wrap) begin
      state_d = next_phase(state_q);
    end
  end

  // phase register, clear has priority over enable
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q <= PH_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode from registered phase and count only
  always_comb begin
    o_sync  = ~SYNC_POL;
    o_act   = 1'b0;
    o_idx   = '0;
    o_last  = 1'b0;
    o_phase = state_q;
    unique case (state_q)
      PH_SYNC: o_sync = SYNC_POL;
      PH_ACT: begin
        o_act = 1'b1;
        o_idx = IDX_W'(cnt);
      end
      PH_FP:   o_last = (cnt == FP_M1);
      default: ;
    endcase
  end

endmodule
